// File: rtl/ann_argmax_decoder.sv
// ann_argmax_decoder: captures layer-2 scores on start and scans them for the winning class.
// Define ANN_ARGMAX_MARGIN_EN to also track the runner-up and report the best-minus-runner-up margin.
module ann_argmax_decoder #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 64,
    parameter int IDX_W       = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores_in,
    output logic                                busy,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [IDX_W-1:0]                    class_idx,
    output logic [SCORE_W-1:0]                  class_score,
    output logic [SCORE_W-1:0]                  margin
);

    localparam int CNT_W = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0] NCLS = CNT_W'(NUM_CLASSES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0] shadow_q, shadow_d;
    logic signed [SCORE_W-1:0]           best_q, best_d;
    logic [IDX_W-1:0]                    best_idx_q, best_idx_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [SCORE_W-1:0]                  score_q, score_d;

    logic [CNT_W-1:0]                    sel;
    logic signed [SCORE_W-1:0]           cur;
    logic                                cur_wins;

    // cnt_q == NUM_CLASSES is the commit cycle; keep the index in range there
    assign sel      = (cnt_q < NCLS) ? cnt_q : '0;
    assign cur      = $signed(shadow_q[sel]);
    assign cur_wins = cur > best_q;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        score_d    = score_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d   = scores_in;
                    best_d     = $signed(scores_in[0]);
                    best_idx_d = '0;
                    cnt_d      = CNT_W'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == NCLS) begin
                    idx_d   = best_idx_q;
                    score_d = best_q;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    if (cur_wins) begin
                        best_d     = cur;
                        best_idx_d = IDX_W'(cnt_q);
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            score_q    <= score_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == HOLD);
    assign class_idx    = idx_q;
    assign class_score  = score_q;

`ifdef ANN_ARGMAX_MARGIN_EN
    localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W-1:0]        S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};

    logic signed [SCORE_W-1:0] second_q, second_d;
    logic [SCORE_W-1:0]        margin_q, margin_d;
    logic [SCORE_W:0]          diff;
    logic [SCORE_W-1:0]        diff_sat;

    // best >= runner-up, so the widened difference is never negative
    assign diff     = {best_q[SCORE_W-1], best_q} - {second_q[SCORE_W-1], second_q};
    assign diff_sat = (diff[SCORE_W] | diff[SCORE_W-1]) ? S_MAX : diff[SCORE_W-1:0];

    always_comb begin
        second_d = second_q;
        margin_d = margin_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    second_d = S_MIN;
                end
            end
            SCAN: begin
                if (cnt_q == NCLS) begin
                    margin_d = diff_sat;
                end else if (cur_wins) begin
                    second_d = best_q;
                end else if (cur > second_q) begin
                    second_d = cur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            second_q <= '0;
            margin_q <= '0;
        end else begin
            second_q <= second_d;
            margin_q <= margin_d;
        end
    end

    assign margin = margin_q;
`else
    assign margin = '0;
`endif

endmodule

// File: tb/tb_ann_argmax_decoder.sv
// Randomized self-checking bench for ann_argmax_decoder against a behavioural argmax model.
// Margin expectations follow ANN_ARGMAX_MARGIN_EN when it is defined for the build.
module tb_ann_argmax_decoder;

    localparam int NC = 10;
    localparam int SW = 64;
    localparam int IW = 4;
`ifdef ANN_ARGMAX_MARGIN_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif
    localparam logic [SW-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [SW-1:0] SMIN = 64'h8000_0000_0000_0000;

    logic                   clk;
    logic                   rstn;
    logic                   start;
    logic [NC-1:0][SW-1:0]  scores_in;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [IW-1:0]          class_idx;
    logic [SW-1:0]          class_score;
    logic [SW-1:0]          margin;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    ann_argmax_decoder #(
        .NUM_CLASSES(NC),
        .SCORE_W(SW),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .scores_in(scores_in),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .class_idx(class_idx),
        .class_score(class_score),
        .margin(margin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: first index of the maximum; runner-up is the max of the rest.
    function automatic void ref_argmax(input logic [NC-1:0][SW-1:0] s,
                                       output int idx, output longint best,
                                       output logic [SW-1:0] mg);
        longint sec;
        bit have;
        logic signed [SW:0] d;
        best = longint'(s[0]);
        idx = 0;
        for (int j = 1; j < NC; j++)
            if (longint'(s[j]) > best) begin
                best = longint'(s[j]);
                idx = j;
            end
        have = 1'b0;
        sec = 0;
        for (int j = 0; j < NC; j++)
            if (j != idx && (!have || longint'(s[j]) > sec)) begin
                sec = longint'(s[j]);
                have = 1'b1;
            end
        d = best;
        d = d - sec;
        if (d > 65'sh0_7FFF_FFFF_FFFF_FFFF) mg = SMAX;
        else mg = d[SW-1:0];
        if (!MEN) mg = '0;
    endfunction

    // Transaction-level model: accept, wait NC cycles, present, retire on handshake.
    bit            m_busy = 0, m_valid = 0, m_had = 0;
    int            m_age = 0;
    int            p_idx = 0, m_idx = 0;
    longint        p_score = 0, m_score = 0;
    logic [SW-1:0] p_margin = '0, m_margin = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_valid = 0; m_had = 0; m_age = 0;
            m_idx = 0; m_score = 0; m_margin = '0;
        end else if (!m_busy) begin
            if (start) begin
                ref_argmax(scores_in, p_idx, p_score, p_margin);
                m_busy = 1;
                m_age = 0;
            end
        end else if (m_valid) begin
            if (result_ready) begin
                m_valid = 0;
                m_busy = 0;
            end
        end else begin
            m_age++;
            if (m_age == NC) begin
                m_valid = 1; m_had = 1;
                m_idx = p_idx; m_score = p_score; m_margin = p_margin;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("valid", result_valid, m_valid);
            if (m_valid || !m_had) begin
                chk("idx", class_idx, m_idx);
                chk("score", class_score, m_score);
                chk("margin", margin, m_margin);
            end
        end
    end

    task automatic wait_valid(output int k);
        k = 0;
        while (!result_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("valid_timeout", result_valid, 1);
    endtask

    task automatic launch(input longint s[NC], input logic rdy);
        @(negedge clk);
        for (int j = 0; j < NC; j++) scores_in[j] = s[j];
        result_ready = rdy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic directed(input string nm, input longint s[NC], input int e_idx,
                            input longint e_score, input logic [63:0] e_mg);
        int k;
        launch(s, 1'b1);
        wait_valid(k);
        chk({nm, "_latency"}, k, 10);
        chk({nm, "_idx"}, class_idx, e_idx);
        chk({nm, "_score"}, class_score, e_score);
        chk({nm, "_margin"}, margin, e_mg);
        chk({nm, "_model_idx"}, m_idx, e_idx);
        chk({nm, "_model_margin"}, m_margin, e_mg);
        @(negedge clk);
        chk({nm, "_drop"}, result_valid, 0);
    endtask

    function automatic logic [SW-1:0] rnd_score(input int mode);
        longint t;
        case (mode)
            0: begin
                t = longint'($urandom_range(0, 8)) - 4;
                return t;
            end
            1: return {$urandom, $urandom};
            default: begin
                case ($urandom_range(0, 3))
                    0: return SMAX;
                    1: return SMIN;
                    2: return '0;
                    default: return '1;
                endcase
            end
        endcase
    endfunction

    initial begin
        longint s[NC];
        int k;
        int mode;
        rstn = 1'b1;
        start = 1'b0;
        result_ready = 1'b0;
        scores_in = '0;
        #1 rstn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_score", class_score, 0);
        chk("rst_margin", margin, 0);
        #19 rstn = 1'b1;
        chk_en = 1'b1;

        s = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
        directed("basic", s, 2, 12, MEN ? 64'd1 : 64'd0);

        s = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -1};
        directed("neg", s, 9, -1, MEN ? 64'd99 : 64'd0);

        s = '{0, 0, 0, 50, 0, 0, 50, 0, 0, 0};
        directed("tie", s, 3, 50, 64'd0);

        s = '{longint'(SMAX), longint'(SMIN), 0, 0, 0, 0, 0, 0, 0, 0};
        directed("sat", s, 0, longint'(SMAX), MEN ? SMAX : 64'd0);

        s = '{1, 2, 3, 4, 5, 6, 7, 8, 90, 9};
        launch(s, 1'b0);
        wait_valid(k);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = (c == 5);
            for (int j = 0; j < NC; j++) scores_in[j] = rnd_score(1);
        end
        start = 1'b0;
        chk("hold_valid", result_valid, 1);
        chk("hold_idx", class_idx, 8);
        chk("hold_score", class_score, 90);
        chk("hold_margin", margin, MEN ? 64'd81 : 64'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("hold_hs_valid", result_valid, 0);
        chk("hold_hs_busy", busy, 0);
        @(negedge clk);
        chk("hold_no_restart", busy, 0);

        s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        launch(s, 1'b1);
        repeat (5) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_idx", class_idx, 0);
        chk("abort_score", class_score, 0);
        chk("abort_margin", margin, 0);
        @(negedge clk);
        rstn = 1'b1;
        s = '{77, 3, 3, 3, 3, 3, 3, 3, 3, 70};
        directed("after_rst", s, 0, 77, MEN ? 64'd7 : 64'd0);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            result_ready = ($urandom_range(0, 2) != 0);
            mode = $urandom_range(0, 2);
            for (int j = 0; j < NC; j++) scores_in[j] = rnd_score(mode);
            if ($urandom_range(0, 399) == 0) begin
                #1 rstn = 1'b0;
                #2 rstn = 1'b1;
            end
        end
        start = 1'b0;
        result_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
